// File: rtl/sdram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sdram_pkg                                                            |
// | Shared FSM encoding, default widths and grant decode for the arbiter |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package sdram_pkg;

    localparam int unsigned AW_DEFAULT = 32;
    localparam int unsigned DW_DEFAULT = 16;
    localparam int unsigned OW_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2,
        ST_DRAIN  = 2'd3
    } state_e;

    // One-hot owner {m1,m0}; no owner outside the two grant states.
    function automatic logic [1:0] grant_of(state_e s);
        logic [1:0] g;
        g = 2'b00;
        if (s == ST_GRANT0) g = 2'b01;
        if (s == ST_GRANT1) g = 2'b10;
        return g;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_wb_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sdram_wb_arbiter_if                                                  |
// | Two Wishbone master ports plus the shared SDRAM-side port            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface sdram_wb_arbiter_if #(
    parameter int AW = sdram_pkg::AW_DEFAULT,
    parameter int DW = sdram_pkg::DW_DEFAULT
) ();
    logic [AW-1:0] m0_address,   m1_address,   s_address;
    logic [DW-1:0] m0_writedata, m1_writedata, s_writedata;
    logic [DW-1:0] m0_readdata,  m1_readdata,  s_readdata;
    logic          m0_strobe, m0_cycle, m0_write, m0_ack, m0_stall;
    logic          m1_strobe, m1_cycle, m1_write, m1_ack, m1_stall;
    logic          s_strobe,  s_cycle,  s_write,  s_ack,  s_stall;

    // Arbiter view: slave toward both masters, master toward the SDRAM.
    modport slave (
        input  m0_address, m0_writedata, m0_strobe, m0_cycle, m0_write,
        input  m1_address, m1_writedata, m1_strobe, m1_cycle, m1_write,
        output m0_readdata, m0_ack, m0_stall,
        output m1_readdata, m1_ack, m1_stall,
        output s_address, s_writedata, s_strobe, s_cycle, s_write,
        input  s_readdata, s_ack, s_stall
    );

    modport master (
        output m0_address, m0_writedata, m0_strobe, m0_cycle, m0_write,
        output m1_address, m1_writedata, m1_strobe, m1_cycle, m1_write,
        input  m0_readdata, m0_ack, m0_stall,
        input  m1_readdata, m1_ack, m1_stall,
        input  s_address, s_writedata, s_strobe, s_cycle, s_write,
        output s_readdata, s_ack, s_stall
    );
endinterface
`default_nettype wire

// File: rtl/sdram_wb_arbiter_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_outstanding_cnt                                                   |
// | Saturating up/down counter of in-flight transfers with error flag    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module wb_outstanding_cnt #(
    parameter int OW = sdram_pkg::OW_DEFAULT
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    input  wire logic          i_inc,
    input  wire logic          i_dec,
    input  wire logic          i_udf_chk,
    output logic [OW-1:0]      o_count,
    output logic               o_err
);
    localparam logic [OW-1:0] c_one = {{(OW-1){1'b0}}, 1'b1};

    logic [OW-1:0] count_q, count_d;

    // Simultaneous inc and dec cancel; either limit holds the value.
    always_comb begin : p_next
        count_d = count_q;
        o_err   = 1'b0;
        if (i_inc && !i_dec) begin
            if (&count_q) o_err   = 1'b1;
            else          count_d = count_q + c_one;
        end else if (i_dec && !i_inc) begin
            if (count_q == '0) o_err   = i_udf_chk;
            else               count_d = count_q - c_one;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin : p_reg
        if (!reset_n) count_q <= '0;
        else          count_q <= count_d;
    end

    assign o_count = count_q;
endmodule
`default_nettype wire

// File: rtl/sdram_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sdram_wb_arbiter                                                     |
// | Round-robin two-master Wishbone arbiter in front of an SDRAM ctrl    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sdram_wb_arbiter
    import sdram_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT,
    parameter int OW = OW_DEFAULT
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    sdram_wb_arbiter_if.slave  bus,
    output logic [1:0]         grant,
    output logic               protocol_err
);
    state_e        state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic [1:0]    grant_q, grant_d;
    logic          err_q, err_d;
    logic          armed_q, armed_d;
    logic          w_inc;
    logic          w_cnt_err;
    logic [OW-1:0] w_count;

    assign w_inc = bus.s_strobe & ~bus.s_stall;

    // Underflow is only an error once this arbiter has issued traffic, so
    // acks still in flight from before a reset are silently dropped.
    wb_outstanding_cnt #(.OW(OW)) u_cnt (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_inc     (w_inc),
        .i_dec     (bus.s_ack),
        .i_udf_chk (armed_q),
        .o_count   (w_count),
        .o_err     (w_cnt_err)
    );

    always_comb begin : p_bus_mux
        bus.s_address   = {AW{1'b0}};
        bus.s_writedata = {DW{1'b0}};
        bus.s_strobe    = 1'b0;
        bus.s_cycle     = 1'b0;
        bus.s_write     = 1'b0;
        bus.m0_readdata = {DW{1'b0}};
        bus.m0_ack      = 1'b0;
        bus.m0_stall    = 1'b1;
        bus.m1_readdata = {DW{1'b0}};
        bus.m1_ack      = 1'b0;
        bus.m1_stall    = 1'b1;
        case (state_q)
            ST_GRANT0: begin
                bus.s_address   = bus.m0_address;
                bus.s_writedata = bus.m0_writedata;
                bus.s_strobe    = bus.m0_strobe;
                bus.s_cycle     = bus.m0_cycle;
                bus.s_write     = bus.m0_write;
                bus.m0_readdata = bus.s_readdata;
                bus.m0_ack      = bus.s_ack;
                bus.m0_stall    = bus.s_stall;
            end
            ST_GRANT1: begin
                bus.s_address   = bus.m1_address;
                bus.s_writedata = bus.m1_writedata;
                bus.s_strobe    = bus.m1_strobe;
                bus.s_cycle     = bus.m1_cycle;
                bus.s_write     = bus.m1_write;
                bus.m1_readdata = bus.s_readdata;
                bus.m1_ack      = bus.s_ack;
                bus.m1_stall    = bus.s_stall;
            end
            ST_DRAIN: bus.s_cycle = 1'b1;
            default: ;
        endcase
    end

    always_comb begin : p_fsm_next
        state_d      = state_q;
        last_grant_d = last_grant_q;
        err_d        = err_q | w_cnt_err;
        armed_d      = armed_q | (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (bus.m0_cycle && bus.m1_cycle)
                    state_d = last_grant_q ? ST_GRANT0 : ST_GRANT1;
                else if (bus.m0_cycle)
                    state_d = ST_GRANT0;
                else if (bus.m1_cycle)
                    state_d = ST_GRANT1;
            end
            ST_GRANT0: begin
                if (!bus.m0_cycle) begin
                    last_grant_d = 1'b0;
                    if (w_count != '0) begin
                        state_d = ST_DRAIN;
                        err_d   = 1'b1;
                    end else begin
                        state_d = bus.m1_cycle ? ST_GRANT1 : ST_IDLE;
                    end
                end
            end
            ST_GRANT1: begin
                if (!bus.m1_cycle) begin
                    last_grant_d = 1'b1;
                    if (w_count != '0) begin
                        state_d = ST_DRAIN;
                        err_d   = 1'b1;
                    end else begin
                        state_d = bus.m0_cycle ? ST_GRANT0 : ST_IDLE;
                    end
                end
            end
            default: begin
                if (w_count == '0) state_d = ST_IDLE;
            end
        endcase
        grant_d = grant_of(state_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin : p_fsm_reg
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 2'b00;
            err_q        <= 1'b0;
            armed_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            err_q        <= err_d;
            armed_q      <= armed_d;
        end
    end

    assign grant        = grant_q;
    assign protocol_err = err_q;
endmodule
`default_nettype wire

// File: tb/tb_sdram_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sdram_wb_arbiter                                                  |
// | Directed plus randomized bench against an owner/count reference model|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_sdram_wb_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 16;
    localparam int OW   = 8;
    localparam int CMAX = (1 << OW) - 1;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] grant;
    logic       protocol_err;

    sdram_wb_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    sdram_wb_arbiter #(.AW(AW), .DW(DW), .OW(OW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus.slave),
        .grant        (grant),
        .protocol_err (protocol_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int acks_m0 = 0;
    int acks_m1 = 0;

    // Reference model: own = -1 none, 0/1 master, 2 draining.
    int own   = -1;
    int last  = 1;
    int outst = 0;
    bit merr  = 1'b0;
    bit armed = 1'b0;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        own = -1; last = 1; outst = 0; merr = 1'b0; armed = 1'b0;
    endtask

    task automatic check_outputs();
        logic [AW+DW+2:0] s_exp, s_got;
        logic [DW+1:0]    r0, r1;
        logic [1:0]       g;
        s_exp = '0;
        r0    = {1'b0, 1'b1, {DW{1'b0}}};
        r1    = r0;
        g     = 2'b00;
        if (own == 0) begin
            s_exp = {bus.m0_cycle, bus.m0_strobe, bus.m0_write, bus.m0_address, bus.m0_writedata};
            r0    = {bus.s_ack, bus.s_stall, bus.s_readdata};
            g     = 2'b01;
        end else if (own == 1) begin
            s_exp = {bus.m1_cycle, bus.m1_strobe, bus.m1_write, bus.m1_address, bus.m1_writedata};
            r1    = {bus.s_ack, bus.s_stall, bus.s_readdata};
            g     = 2'b10;
        end else if (own == 2) begin
            s_exp = {1'b1, {(AW+DW+2){1'b0}}};
        end
        s_got = {bus.s_cycle, bus.s_strobe, bus.s_write, bus.s_address, bus.s_writedata};
        chk("grant",   64'(grant), 64'(g));
        chk("perr",    64'(protocol_err), 64'(merr));
        chk("s_bus",   64'(s_got), 64'(s_exp));
        chk("m0_resp", 64'({bus.m0_ack, bus.m0_stall, bus.m0_readdata}), 64'(r0));
        chk("m1_resp", 64'({bus.m1_ack, bus.m1_stall, bus.m1_readdata}), 64'(r1));
    endtask

    task automatic model_clock();
        logic strb, inc, dec, c0, c1;
        int   nout, nown;
        c0   = bus.m0_cycle;
        c1   = bus.m1_cycle;
        strb = (own == 0) ? bus.m0_strobe : (own == 1) ? bus.m1_strobe : 1'b0;
        inc  = strb && !bus.s_stall;
        dec  = bus.s_ack;
        nout = outst;
        if (inc && !dec) begin
            if (outst == CMAX) merr = 1'b1; else nout = outst + 1;
        end else if (dec && !inc) begin
            if (outst == 0) begin if (armed) merr = 1'b1; end
            else nout = outst - 1;
        end
        nown = own;
        if (own == -1) begin
            if (c0 && c1) nown = (last == 1) ? 0 : 1;
            else if (c0)  nown = 0;
            else if (c1)  nown = 1;
        end else if (own == 0 || own == 1) begin
            if (!((own == 0) ? c0 : c1)) begin
                last = own;
                if (outst > 0) begin nown = 2; merr = 1'b1; end
                else if ((own == 0) ? c1 : c0) nown = 1 - own;
                else nown = -1;
            end
        end else if (outst == 0) begin
            nown = -1;
        end
        if (own != -1) armed = 1'b1;
        own   = nown;
        outst = nout;
    endtask

    // Called at posedge+1 with inputs already applied; returns at posedge+1.
    task automatic step();
        #1;
        check_outputs();
        acks_m0 += int'(bus.m0_ack);
        acks_m1 += int'(bus.m1_ack);
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic drv0(bit c, bit s, bit w);
        bus.m0_cycle = c; bus.m0_strobe = s; bus.m0_write = w;
        bus.m0_address = $urandom; bus.m0_writedata = DW'($urandom);
    endtask

    task automatic drv1(bit c, bit s, bit w);
        bus.m1_cycle = c; bus.m1_strobe = s; bus.m1_write = w;
        bus.m1_address = $urandom; bus.m1_writedata = DW'($urandom);
    endtask

    task automatic slv(bit ack, bit stall);
        bus.s_ack = ack; bus.s_stall = stall; bus.s_readdata = DW'($urandom);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drv0(1'b0, 1'b0, 1'b0); drv1(1'b0, 1'b0, 1'b0); slv(1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_outputs();
        reset_n = 1'b1;

        // Simultaneous request after reset: m0 first, then direct handover.
        drv0(1'b1, 1'b0, 1'b0); drv1(1'b1, 1'b0, 1'b0); step();
        chk("tie_m0_first", 64'(grant), 64'(2'b01));
        drv0(1'b0, 1'b0, 1'b0); step();
        chk("direct_handover", 64'(grant), 64'(2'b10));
        drv1(1'b0, 1'b0, 1'b0); step();
        chk("back_to_idle", 64'(grant), 64'(2'b00));

        // Both masters keep cycle high: grant must alternate.
        drv0(1'b1, 1'b0, 1'b0); drv1(1'b1, 1'b0, 1'b0); step();
        for (int b = 0; b < 6; b++) begin
            chk("rr_grant", 64'(grant), 64'((b % 2 == 1) ? 2'b10 : 2'b01));
            if (b % 2 == 0) drv0(1'b1, 1'b1, 1'b1); else drv1(1'b1, 1'b1, 1'b1);
            slv(1'b1, 1'b0); step();
            if (b % 2 == 0) drv0(1'b0, 1'b0, 1'b0); else drv1(1'b0, 1'b0, 1'b0);
            slv(1'b0, 1'b0); step();
            if (b % 2 == 0) drv0(1'b1, 1'b0, 1'b0); else drv1(1'b1, 1'b0, 1'b0);
        end
        drv0(1'b0, 1'b0, 1'b0); drv1(1'b0, 1'b0, 1'b0); step();

        // m0 alone: four writes, each acked two cycles after acceptance.
        acks_m0 = 0;
        for (int t = 0; t < 8; t++) begin
            drv0(t < 7, t < 5, 1'b1);
            slv(t >= 3 && t <= 6, 1'b0);
            step();
            if (t == 0) chk("m0_grant_latency", 64'(grant), 64'(2'b01));
        end
        chk("m0_ack_count", 64'(acks_m0), 64'(4));

        // Randomized well-behaved traffic.
        for (int i = 0; i < 500; i++) begin
            if (own == 0) begin
                if (outst == 0 && $urandom_range(3) == 0) drv0(1'b0, 1'b0, 1'($urandom));
                else drv0(1'b1, 1'($urandom), 1'($urandom));
            end else drv0(1'($urandom), 1'($urandom), 1'($urandom));
            if (own == 1) begin
                if (outst == 0 && $urandom_range(3) == 0) drv1(1'b0, 1'b0, 1'($urandom));
                else drv1(1'b1, 1'($urandom), 1'($urandom));
            end else drv1(1'($urandom), 1'($urandom), 1'($urandom));
            slv(outst > 0 && $urandom_range(1) == 1, $urandom_range(3) == 0);
            step();
        end
        chk("random_no_err", 64'(protocol_err), 64'(0));

        // Settle to idle, then a spurious ack.
        for (int k = 0; k < 400 && own != -1; k++) begin
            if (outst > 0) begin
                drv0(own == 0, 1'b0, 1'b0); drv1(own == 1, 1'b0, 1'b0); slv(1'b1, 1'b0);
            end else begin
                drv0(1'b0, 1'b0, 1'b0); drv1(1'b0, 1'b0, 1'b0); slv(1'b0, 1'b0);
            end
            step();
        end
        drv0(1'b0, 1'b0, 1'b0); drv1(1'b0, 1'b0, 1'b0);
        chk("settled_idle", 64'(grant), 64'(2'b00));
        slv(1'b1, 1'b0); step();
        chk("spurious_ack_err", 64'(protocol_err), 64'(1));
        slv(1'b0, 1'b0); drv0(1'b1, 1'b0, 1'b0); step();
        drv0(1'b0, 1'b0, 1'b0); step();
        chk("no_underflow", 64'(bus.s_cycle), 64'(0));

        // m1 three reads, drops cycle after one ack.
        do_reset();
        drv1(1'b1, 1'b0, 1'b0); slv(1'b0, 1'b0); step();
        chk("m1_grant", 64'(grant), 64'(2'b10));
        for (int t = 0; t < 3; t++) begin drv1(1'b1, 1'b1, 1'b0); step(); end
        drv1(1'b1, 1'b0, 1'b0); slv(1'b1, 1'b0); step();
        drv1(1'b0, 1'b0, 1'b0); slv(1'b0, 1'b0); step();
        chk("drain_err", 64'(protocol_err), 64'(1));
        acks_m1 = 0;
        slv(1'b1, 1'b0); step(); step();
        chk("drain_acks_hidden", 64'(acks_m1), 64'(0));
        chk("drain_cycle_held", 64'(bus.s_cycle), 64'(1));
        slv(1'b0, 1'b0); step();
        chk("drain_done_cycle", 64'(bus.s_cycle), 64'(0));
        chk("drain_done_grant", 64'(grant), 64'(2'b00));

        // Counter saturation at all-ones.
        do_reset();
        drv0(1'b1, 1'b1, 1'b1); slv(1'b0, 1'b0); step();
        for (int i = 0; i < CMAX; i++) step();
        chk("pre_overflow", 64'(protocol_err), 64'(0));
        step();
        chk("overflow_err", 64'(protocol_err), 64'(1));

        // Reset mid-burst; late acks ignored; next tie goes to m0.
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk("rst_s_cycle", 64'(bus.s_cycle), 64'(0));
        chk("rst_s_strobe", 64'(bus.s_strobe), 64'(0));
        @(posedge clk);
        #1;
        drv0(1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        slv(1'b1, 1'b0);
        repeat (3) step();
        chk("late_acks_ignored", 64'(protocol_err), 64'(0));
        slv(1'b0, 1'b0); drv0(1'b1, 1'b0, 1'b0); drv1(1'b1, 1'b0, 1'b0); step();
        chk("post_reset_tie", 64'(grant), 64'(2'b01));
        drv0(1'b0, 1'b0, 1'b0); drv1(1'b0, 1'b0, 1'b0); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sdram_wb_arbiter.md
SDRAM_WB_ARBITER -- requirements
Module: sdram_wb_arbiter

Interface
REQ-001 Parameter AW, default 32, Wishbone address width.
REQ-002 Parameter DW, default 16, Wishbone data width.
REQ-003 Parameter OW, default 8, outstanding-transfer counter width.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous and active-low.
REQ-006 mN_address  input  AW  master N address; N = 0, 1 for all mN_* ports.
REQ-007 mN_writedata  input  DW  master N write data.
REQ-008 mN_readdata  output  DW  read data to master N.
REQ-009 mN_strobe, mN_cycle, mN_write  input  1 each  master N strobe, cycle and write enable.
REQ-010 mN_ack, mN_stall  output  1 each  master N acknowledge and stall.
REQ-011 s_address, s_writedata, s_strobe, s_cycle, s_write  output  AW/DW/1/1/1  toward the SDRAM controller.
REQ-012 s_readdata, s_ack, s_stall  input  DW/1/1  from the SDRAM controller.
REQ-013 grant  output  2  one-hot owner {m1,m0}; 00 = none.
REQ-014 protocol_err  output  1  sticky error flag.

Function
REQ-015 FSM states: ST_IDLE, ST_GRANT0, ST_GRANT1, ST_DRAIN.
REQ-016 ST_IDLE: if only mN_cycle is high -> ST_GRANTN. If both are high -> grant the master that is not last_grant. Grant is visible the cycle after the request (1-cycle arbitration latency).
REQ-017 ST_GRANTN: s_* outputs equal mN_* combinationally. mN_stall = s_stall. mN_ack = s_ack. mN_readdata = s_readdata.
REQ-018 Non-granted master (and both masters outside ST_GRANTn): stall=1, ack=0, readdata=0.
REQ-019 ST_IDLE and ST_DRAIN: s_strobe=0, s_write=0, s_address=0, s_writedata=0. s_cycle=1 only in ST_DRAIN.
REQ-020 Outstanding counter: +1 when s_strobe && !s_stall, -1 when s_ack. Both in the same cycle -> unchanged.
REQ-021 Owner drops mN_cycle with outstanding==0 -> if the other master's cycle is high, hand over directly to ST_GRANT(other); else -> ST_IDLE. last_grant <= N.
REQ-022 Owner drops mN_cycle with outstanding>0 -> ST_DRAIN and protocol_err <= 1.
REQ-023 ST_DRAIN: hold s_cycle=1, discard s_ack (no master sees it), count down. At outstanding==0 -> ST_IDLE.
REQ-024 s_ack while outstanding==0 -> protocol_err <= 1; counter saturates at 0 (no underflow).
REQ-025 Counter at all-ones with a new accepted strobe -> protocol_err <= 1; counter saturates (no wrap).
REQ-026 protocol_err clears only on reset.
REQ-027 grant is registered and equals the FSM state (10/01 in GRANT1/GRANT0, 00 otherwise).
REQ-028 No master is granted twice in a row while the other master's cycle is held high continuously (round-robin fairness).

Reset
REQ-029 reset_n low: state=ST_IDLE, last_grant=1 (so m0 wins the first tie), outstanding=0, protocol_err=0, grant=00.
REQ-030 Reset asserted mid-burst: all master and slave strobe/cycle outputs go to 0 immediately. In-flight acks after reset are ignored without setting protocol_err.

Structure
REQ-031 State encodings and default parameter values live in shared package sdram_pkg.
REQ-032 Optional sub-module wb_outstanding_cnt (saturating up/down counter with an error output). The rest is a single module.

Verification
REQ-033 Only m0 requests, 4 writes, slave stall=0, acks 2 cycles later -> grant=01 one cycle after m0_cycle; 4 m0_acks; m1_stall=1 throughout.
REQ-034 m0 and m1 raise cycle in the same cycle after reset -> m0 granted first. m0 drops cycle with outstanding=0 -> grant=10 on the next cycle, with no ST_IDLE gap.
REQ-035 Both masters hold cycle continuously for 6 bursts -> grant alternates 01,10,01,10,01,10.
REQ-036 m1 issues 3 reads, drops cycle after 1 ack -> protocol_err=1; 2 further acks are not forwarded; s_cycle stays 1 until the 3rd ack, then FSM returns to IDLE.
REQ-037 Spurious s_ack in ST_IDLE -> protocol_err=1, outstanding stays 0.
REQ-038 reset_n pulsed low mid-burst -> all outputs at reset values within the same cycle; the next grant tie goes to m0.
